// File: rtl/modo_primitivo.sv
// Purpose : level tracker (0..LEVEL_MAX) for the primitive mode; counts filtered rising edges of the level-up request.
// Latency : Nivel steps on the (FILTER_CYCLES+3)-th clk edge after the request is first sampled high.
// Backpress: none; a rise seen while activo=0 or at LEVEL_MAX is dropped, never queued.
//
// Ports:
//   clk                 system clock, rising edge
//   B_reset             synchronous active-low reset
//   Entrada_Sube_Nivel  asynchronous/noisy level-up request
//   activo              1 = this mode owns the level
//   Nivel[1:0]          current level, registered
//
// Optional build macro: MODO_PRIMITIVO_DECAY_EN
//   When defined, Nivel loses one step after DECAY_CYCLES idle cycles with activo=1.
module modo_primitivo #(
    parameter int FILTER_CYCLES = 4,
    parameter int LEVEL_MAX     = 3,
    parameter int DECAY_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       B_reset,
    input  logic       Entrada_Sube_Nivel,
    input  logic       activo,
    output logic [1:0] Nivel
);

    // Catch illegal parameter combinations at elaboration time.
    if (FILTER_CYCLES < 1 || LEVEL_MAX < 0 || LEVEL_MAX > 3 || DECAY_CYCLES < 1) begin : g_bad_param
        $error("modo_primitivo: illegal parameter value");
    end

    localparam int              CW      = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0]   FC_LAST = CW'(FILTER_CYCLES - 1);
    localparam logic [1:0]      LVL_MAX = 2'(LEVEL_MAX);

    logic          sync1;
    logic          sync2;
    logic          filtered;
    logic          filtered_prev;
    logic [CW-1:0] flt_cnt;
    logic          rise;
    logic          level_up;

    assign rise     = filtered & ~filtered_prev;
    assign level_up = rise & activo & (Nivel < LVL_MAX);

`ifdef MODO_PRIMITIVO_DECAY_EN
    localparam int            TW         = $clog2(DECAY_CYCLES) + 1;
    localparam logic [TW-1:0] DECAY_LAST = TW'(DECAY_CYCLES - 1);

    logic [TW-1:0] decay_tmr;
`endif

    always_ff @(posedge clk) begin
        if (!B_reset) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            filtered      <= 1'b0;
            filtered_prev <= 1'b0;
            flt_cnt       <= '0;
            Nivel         <= 2'd0;
`ifdef MODO_PRIMITIVO_DECAY_EN
            decay_tmr     <= '0;
`endif
        end else begin
            sync1 <= Entrada_Sube_Nivel;
            sync2 <= sync1;

            // The filtered level only follows sync2 once it has disagreed for
            // FILTER_CYCLES consecutive cycles; any agreement restarts the count.
            if (sync2 == filtered) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FC_LAST) begin
                filtered <= sync2;
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end

            // Tracks regardless of activo so a rise that happened while the
            // mode was inactive is consumed rather than seen later.
            filtered_prev <= filtered;

`ifdef MODO_PRIMITIVO_DECAY_EN
            // Level-up has priority over decay; both restart the idle timer.
            if (level_up) begin
                Nivel     <= Nivel + 2'd1;
                decay_tmr <= '0;
            end else if (!activo || Nivel == 2'd0) begin
                decay_tmr <= '0;
            end else if (decay_tmr == DECAY_LAST) begin
                Nivel     <= Nivel - 2'd1;
                decay_tmr <= '0;
            end else begin
                decay_tmr <= decay_tmr + 1'b1;
            end
`else
            if (level_up) begin
                Nivel <= Nivel + 2'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_modo_primitivo.sv
// Purpose : self-checking bench for modo_primitivo with a change scoreboard and a point-check scoreboard.
// Latency : expected Nivel changes are stamped with the exact clk edge on which they must appear.
// Backpress: not applicable.
module tb_modo_primitivo;

    localparam int FC  = 4;
    localparam int DCY = 1000;

    logic       clk;
    logic       B_reset;
    logic       Entrada_Sube_Nivel;
    logic       activo;
    logic [1:0] Nivel;

    typedef struct {
        int         cyc;
        logic [1:0] val;
        string      name;
    } exp_t;

    exp_t chg_q[$];
    exp_t pt_q[$];

    int         ecnt  = 0;
    int         total = 0;
    int         bad   = 0;
    logic [1:0] last  = 2'd0;

    modo_primitivo #(
        .FILTER_CYCLES(FC),
        .LEVEL_MAX    (3),
        .DECAY_CYCLES (DCY)
    ) dut (
        .clk               (clk),
        .B_reset           (B_reset),
        .Entrada_Sube_Nivel(Entrada_Sube_Nivel),
        .activo            (activo),
        .Nivel             (Nivel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    // Monitor: every Nivel change must match the next expected change (value and
    // edge); point checks fire on their scheduled edge.
    always @(negedge clk) begin
        exp_t e;
        if (ecnt >= 1) begin
            if (Nivel !== last) begin
                total++;
                if (chg_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change edge=%0d got=%0d was=%0d", ecnt, Nivel, last);
                end else begin
                    e = chg_q.pop_front();
                    if (e.val !== Nivel || e.cyc != ecnt) begin
                        bad++;
                        $display("FAIL %s got=%0d@edge%0d want=%0d@edge%0d", e.name, Nivel, ecnt, e.val, e.cyc);
                    end
                end
                last = Nivel;
            end
            while (pt_q.size() > 0 && pt_q[0].cyc <= ecnt) begin
                e = pt_q.pop_front();
                total++;
                if (e.val !== Nivel || e.cyc != ecnt) begin
                    bad++;
                    $display("FAIL %s got=%0d@edge%0d want=%0d@edge%0d", e.name, Nivel, ecnt, e.val, e.cyc);
                end
            end
        end
    end

    task automatic exp_chg(input int dly, input logic [1:0] v, input string nm);
        exp_t e;
        e.cyc = ecnt + dly; e.val = v; e.name = nm;
        chg_q.push_back(e);
    endtask

    task automatic exp_pt(input int dly, input logic [1:0] v, input string nm);
        exp_t e;
        e.cyc = ecnt + dly; e.val = v; e.name = nm;
        pt_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge: request high for hi cycles then low for lo cycles.
    task automatic pulse(input int hi, input int lo, input bit counted, input logic [1:0] v, input string nm);
        Entrada_Sube_Nivel = 1'b1;
        if (counted) exp_chg(FC + 3, v, nm);
        idle(hi);
        Entrada_Sube_Nivel = 1'b0;
        idle(lo);
    endtask

    task automatic reset_pulse(input bit from_nonzero);
        B_reset = 1'b0;
        if (from_nonzero) exp_chg(1, 2'd0, "reset_clear");
        idle(1);
        B_reset = 1'b1;
    endtask

    initial begin
        B_reset            = 1'b0;
        activo             = 1'b0;
        Entrada_Sube_Nivel = 1'b0;

        // Reset held with the input toggling.
        @(negedge clk);
        exp_pt(1, 2'd0, "reset_hold_a");
        exp_pt(2, 2'd0, "reset_hold_b");
        Entrada_Sube_Nivel = 1'b1;
        idle(1);
        Entrada_Sube_Nivel = 1'b0;
        idle(1);
        Entrada_Sube_Nivel = 1'b1;
        idle(1);
        Entrada_Sube_Nivel = 1'b0;
        B_reset = 1'b1;
        exp_pt(5, 2'd0, "after_reset");
        idle(10);

        // Counting and saturation.
        activo = 1'b1;
        pulse(150, 150, 1, 2'd1, "count_1");
        pulse(150, 150, 1, 2'd2, "count_2");
        pulse(150, 150, 1, 2'd3, "count_3");
        pulse(150, 150, 0, 2'd3, "sat");
        exp_pt(1, 2'd3, "saturated");
        idle(2);
        activo = 1'b0;
        idle(5);

        // Reset mid-operation with the request held high.
        reset_pulse(1);
        activo = 1'b1;
        idle(2);
        pulse(6, 20, 1, 2'd1, "pre_mid_1");
        pulse(6, 20, 1, 2'd2, "pre_mid_2");
        Entrada_Sube_Nivel = 1'b1;
        idle(3);
        B_reset = 1'b0;
        exp_chg(1, 2'd0, "mid_reset_clear");
        idle(1);
        B_reset = 1'b1;
        exp_chg(FC + 3, 2'd1, "mid_reset_recount");
        idle(30);
        Entrada_Sube_Nivel = 1'b0;
        idle(20);

        // Glitch filter: shorter than FC cycles is dropped, exactly FC counts.
        pulse(2, 20, 0, 2'd1, "glitch_2");
        pulse(FC - 1, 20, 0, 2'd1, "glitch_3");
        exp_pt(1, 2'd1, "glitch_dropped");
        idle(2);
        pulse(FC, 20, 1, 2'd2, "pulse_4");

        // Enable gating.
        activo = 1'b0;
        pulse(150, 150, 0, 2'd2, "inactive");
        exp_pt(1, 2'd2, "inactive_hold");
        Entrada_Sube_Nivel = 1'b1;
        idle(20);
        activo = 1'b1;
        idle(20);
        exp_pt(1, 2'd2, "late_activo");
        Entrada_Sube_Nivel = 1'b0;
        idle(20);
        pulse(6, 20, 1, 2'd3, "gate_reenable");
        activo = 1'b0;
        idle(30);
        exp_pt(1, 2'd3, "retained");
        idle(2);

`ifdef MODO_PRIMITIVO_DECAY_EN
        // Decay: one step per DCY idle cycles with activo=1, frozen while activo=0.
        reset_pulse(1);
        activo = 1'b1;
        idle(2);
        pulse(6, 20, 1, 2'd1, "decay_up_1");
        Entrada_Sube_Nivel = 1'b1;
        exp_chg(FC + 3, 2'd2, "decay_up_2");
        exp_chg(FC + 3 + DCY, 2'd1, "decay_step_1");
        exp_chg(FC + 3 + 2 * DCY, 2'd0, "decay_step_0");
        idle(6);
        Entrada_Sube_Nivel = 1'b0;
        idle(2 * DCY + 20);
        exp_pt(1, 2'd0, "decay_floor");
        idle(2);
        Entrada_Sube_Nivel = 1'b1;
        exp_chg(FC + 3, 2'd1, "decay_up_3");
        idle(6);
        Entrada_Sube_Nivel = 1'b0;
        idle(2);
        activo = 1'b0;
        idle(DCY + 50);
        exp_pt(1, 2'd1, "decay_frozen");
        idle(2);
        activo = 1'b1;
        exp_chg(DCY, 2'd0, "decay_resume");
        idle(DCY + 10);
`endif

        idle(10);
        total++;
        if (chg_q.size() != 0) begin
            bad++;
            $display("FAIL pending_changes left=%0d want=0 first=%s", chg_q.size(), chg_q[0].name);
        end
        total++;
        if (pt_q.size() != 0) begin
            bad++;
            $display("FAIL pending_points left=%0d want=0", pt_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
